rr_arbiter_16: RTL and testbench
================================

RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

Interface
REQ-001 Parameter HOLD_MAX, default 16: max grant length in cycles, legal range 1..255.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 REQ  input  16  request per requester; bit i = requester i.
REQ-005 EN  input  16  per-requester enable; eligible = REQ & EN.
REQ-006 DONE  input  1  shared-resource transfer-complete strobe for current owner.
REQ-007 GNT  output  16  registered one-hot grant; all-zero when idle.
REQ-008 SEL  output  4  registered index of owner; drives the SEL of the 16:1 datapath mux.
REQ-009 BUSY  output  1  registered; high while any grant is active.
REQ-010 TIMEOUT_ERR  output  1  registered one-cycle pulse on forced release.

Function
REQ-011 Two states: IDLE (no owner) and GRANT (one owner); encodings are localparams.
REQ-012 Winner = first eligible index searching LAST+1, LAST+2, ... wrapping mod 16, ending with LAST itself.
REQ-013 IDLE: if eligible != 0 at edge k, GNT/SEL/BUSY reflect winner after edge k (one-cycle latency), state -> GRANT.
REQ-014 IDLE with eligible == 0: outputs unchanged; SEL retains last value; DONE ignored.
REQ-015 GRANT: 8-bit hold counter starts at 0 on grant and increments each cycle owner is held.
REQ-016 Release occurs on any of: DONE=1, REQ[SEL]=0, or counter == HOLD_MAX-1.
REQ-017 Timeout release (counter == HOLD_MAX-1 with DONE=0 and REQ[SEL]=1) pulses TIMEOUT_ERR for exactly the following cycle.
REQ-018 On release, LAST <= SEL and arbitration runs in the same cycle with the advanced pointer; the new owner appears after that edge with no idle gap.
REQ-019 On release with eligible == 0 (or only owner eligible but owner's REQ dropped): GNT=0, BUSY=0, state -> IDLE.
REQ-020 Owner re-wins only when no other requester is eligible; its counter restarts at 0.
REQ-021 Deasserting EN[SEL] during GRANT does not revoke the grant; it only excludes that requester from the next arbitration.
REQ-022 New requests arriving during GRANT never preempt the owner.
REQ-023 GNT always one-hot or zero; GNT[SEL]=1 whenever BUSY=1.
REQ-024 DONE and timeout in the same cycle count as DONE; TIMEOUT_ERR not pulsed.

Reset
REQ-025 RST at an edge forces: state IDLE, GNT=0, SEL=0, BUSY=0, TIMEOUT_ERR=0, counter=0, LAST=15 (requester 0 has first priority).
REQ-026 RST asserted mid-grant drops the grant at that edge; requests are ignored while RST=1.

Structure
REQ-027 No shared package; state encodings and counter width are localparams inside the module.
REQ-028 One combinational sub-module, rr_prio_enc_16: inputs eligible[15:0], LAST[3:0]; outputs winner index[3:0] and found flag.
REQ-029 All outputs come directly from flops; no combinational path from REQ/DONE to GNT/SEL.

Verification
REQ-030 Reset then REQ=16'h0001, EN=16'hFFFF -> after one edge GNT=16'h0001, SEL=0, BUSY=1.
REQ-031 REQ=16'h8421 held, DONE pulsed each grant cycle -> grants rotate SEL 0,5,10,15,0 back-to-back with no idle cycle.
REQ-032 HOLD_MAX=4, REQ=16'h0010 held, DONE=0 -> GNT held 4 cycles, TIMEOUT_ERR pulses once, requester 4 re-granted, counter restarts.
REQ-033 Owner 3 drops REQ while REQ[7]=1 -> next edge GNT=16'h0080, SEL=7; EN=16'hFF7F instead -> IDLE, BUSY=0, SEL stays 3.
REQ-034 RST asserted during grant of requester 9 -> next edge GNT=0, SEL=0, BUSY=0; after release with REQ=16'hFFFF, requester 0 wins first.
REQ-035 Random REQ/EN/DONE, 10k cycles -> scoreboard checks one-hot GNT, GNT[SEL] when BUSY, no starvation beyond 16*HOLD_MAX cycles.

Source files
------------

// File: rtl/rr_prio_enc_16.sv
// rtl/rr_prio_enc_16.sv - round-robin priority encoder: first eligible index after last, wrapping to last itself
module rr_prio_enc_16 (
    input  logic [15:0] eligible,
    input  logic [3:0]  last,
    output logic [3:0]  winner,
    output logic        found
);

    logic [3:0] idx;

    // k == 16 wraps to last itself, so the previous owner is searched last
    always_comb begin
        winner = 4'd0;
        found  = 1'b0;
        idx    = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            idx = last + 4'(k);
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// rtl/rr_arbiter_16.sv - 16-way round-robin arbiter with hold limit, done/drop release and timeout pulse
module rr_arbiter_16 #(
    parameter int HOLD_MAX = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] REQ,
    input  logic [15:0] EN,
    input  logic        DONE,
    output logic [15:0] GNT,
    output logic [3:0]  SEL,
    output logic        BUSY,
    output logic        TIMEOUT_ERR
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;
    localparam int   CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    logic             state_q, state_d;
    logic [15:0]      gnt_q, gnt_d;
    logic [3:0]       sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             tout_q, tout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       last_q, last_d;

    logic [15:0] eligible;
    logic [3:0]  enc_last;
    logic [3:0]  winner;
    logic        found;
    logic        owner_req;
    logic        at_limit;
    logic        release_now;

    assign eligible    = REQ & EN;
    // On release the pointer advances to the current owner in the same cycle
    assign enc_last    = (state_q == ST_GRANT) ? sel_q : last_q;
    assign owner_req   = REQ[sel_q];
    assign at_limit    = (cnt_q == CNT_LAST);
    assign release_now = DONE | ~owner_req | at_limit;

    rr_prio_enc_16 u_prio_enc (
        .eligible (eligible),
        .last     (enc_last),
        .winner   (winner),
        .found    (found)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        tout_d  = 1'b0;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_GRANT;
                    gnt_d   = 16'h0001 << winner;
                    sel_d   = winner;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (release_now) begin
                    tout_d = at_limit & ~DONE & owner_req;
                    last_d = sel_q;
                    if (found) begin
                        gnt_d  = 16'h0001 << winner;
                        sel_d  = winner;
                        busy_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 4'hF;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            tout_q  <= tout_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign GNT         = gnt_q;
    assign SEL         = sel_q;
    assign BUSY        = busy_q;
    assign TIMEOUT_ERR = tout_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb/tb_rr_arbiter_16.sv - scoreboard bench for rr_arbiter_16 with directed and random stimulus
module tb_rr_arbiter_16;

    localparam int HOLD = 4;

    logic        CLK;
    logic        RST;
    logic [15:0] REQ;
    logic [15:0] EN;
    logic        DONE;
    logic [15:0] GNT;
    logic [3:0]  SEL;
    logic        BUSY;
    logic        TIMEOUT_ERR;

    rr_arbiter_16 #(.HOLD_MAX(HOLD)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REQ         (REQ),
        .EN          (EN),
        .DONE        (DONE),
        .GNT         (GNT),
        .SEL         (SEL),
        .BUSY        (BUSY),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [15:0] gnt;
        logic [3:0]  sel;
        logic        busy;
        logic        tout;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // reference model state
    logic m_busy;
    int   m_sel;
    int   m_cnt;
    int   m_last;
    logic m_tout;

    // starvation tracking
    logic        track_starve;
    int          wait_cnt[16];
    int          max_wait;
    logic [15:0] applied_elig;
    logic        applied_rst;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_search(input logic [15:0] elig, input int from);
        for (int k = 1; k <= 16; k++) begin
            int idx;
            idx = (from + k) % 16;
            if (elig[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [15:0] req, input logic [15:0] en,
                              input logic done);
        int w;
        logic [15:0] elig;
        elig = req & en;
        if (rst) begin
            m_busy = 1'b0; m_sel = 0; m_cnt = 0; m_last = 15; m_tout = 1'b0;
        end else begin
            m_tout = 1'b0;
            if (!m_busy) begin
                w = rr_search(elig, m_last);
                if (w >= 0) begin
                    m_busy = 1'b1; m_sel = w; m_cnt = 0;
                end
            end else if (done || !req[m_sel] || m_cnt == HOLD - 1) begin
                m_tout = !done && req[m_sel] && (m_cnt == HOLD - 1);
                m_last = m_sel;
                w = rr_search(elig, m_last);
                if (w >= 0) begin
                    m_sel = w; m_cnt = 0;
                end else begin
                    m_busy = 1'b0; m_cnt = 0;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic cycle(input string tag, input logic rst, input logic [15:0] req,
                         input logic [15:0] en, input logic done);
        exp_t e;
        RST = rst; REQ = req; EN = en; DONE = done;
        applied_elig = req & en;
        applied_rst  = rst;
        model_step(rst, req, en, done);
        e.gnt  = m_busy ? (16'h0001 << m_sel) : 16'h0000;
        e.sel  = 4'(m_sel);
        e.busy = m_busy;
        e.tout = m_tout;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_gnt"}, 32'(GNT), 32'(e.gnt));
            check_eq({tag, "_sel"}, 32'(SEL), 32'(e.sel));
            check_eq({tag, "_busy"}, 32'(BUSY), 32'(e.busy));
            check_eq({tag, "_tout"}, 32'(TIMEOUT_ERR), 32'(e.tout));
        end
        check_eq({tag, "_onehot"}, 32'($countones(GNT) <= 1), 32'd1);
        if (BUSY) check_eq({tag, "_gnt_sel"}, 32'(GNT[SEL]), 32'd1);
        if (track_starve) begin
            for (int i = 0; i < 16; i++) begin
                if (applied_rst || GNT[i] || !applied_elig[i]) wait_cnt[i] = 0;
                else wait_cnt[i] = wait_cnt[i] + 1;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
    endtask

    task automatic do_reset();
        cycle("rst", 1'b1, 16'h0000, 16'hFFFF, 1'b0);
    endtask

    initial begin
        logic [19:0] seq;
        logic        all_busy;
        logic [5:0]  tout_v;
        logic        held;
        logic [15:0] rreq;
        logic [15:0] ren;
        logic [31:0] r;

        RST = 1'b1; REQ = '0; EN = '0; DONE = 1'b0;
        m_busy = 1'b0; m_sel = 0; m_cnt = 0; m_last = 15; m_tout = 1'b0;
        track_starve = 1'b0; max_wait = 0;
        for (int i = 0; i < 16; i++) wait_cnt[i] = 0;

        do_reset();
        do_reset();
        check_eq("reset_gnt", 32'(GNT), 32'h0);
        check_eq("reset_sel", 32'(SEL), 32'h0);
        check_eq("reset_busy", 32'(BUSY), 32'h0);
        check_eq("reset_tout", 32'(TIMEOUT_ERR), 32'h0);

        // single requester, one-cycle latency
        cycle("r030", 1'b0, 16'h0001, 16'hFFFF, 1'b0);
        check_eq("r030_gnt", 32'(GNT), 32'h0001);
        check_eq("r030_busy", 32'(BUSY), 32'h1);

        // back-to-back rotation driven by DONE
        do_reset();
        seq = '0; all_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle("r031", 1'b0, 16'h8421, 16'hFFFF, 1'b1);
            seq = {seq[15:0], SEL};
            all_busy = all_busy & BUSY;
        end
        check_eq("r031_seq", 32'(seq), 32'h05AF0);
        check_eq("r031_no_gap", 32'(all_busy), 32'h1);

        // hold limit reached with owner still requesting
        do_reset();
        tout_v = '0; held = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle("r032", 1'b0, 16'h0010, 16'hFFFF, 1'b0);
            tout_v[i] = TIMEOUT_ERR;
            held = held & (GNT == 16'h0010);
        end
        check_eq("r032_tout_pattern", 32'(tout_v), 32'h10);
        check_eq("r032_held", 32'(held), 32'h1);

        // DONE coinciding with the hold limit is a normal release
        do_reset();
        for (int i = 0; i < 4; i++) cycle("r024", 1'b0, 16'h0010, 16'hFFFF, 1'b0);
        cycle("r024", 1'b0, 16'h0010, 16'hFFFF, 1'b1);
        check_eq("r024_tout", 32'(TIMEOUT_ERR), 32'h0);
        check_eq("r024_gnt", 32'(GNT), 32'h0010);

        // owner drops request, other requester takes over
        do_reset();
        cycle("r033a", 1'b0, 16'h0008, 16'hFFFF, 1'b0);
        check_eq("r033a_sel3", 32'(SEL), 32'h3);
        cycle("r033a", 1'b0, 16'h0080, 16'hFFFF, 1'b0);
        check_eq("r033a_gnt", 32'(GNT), 32'h0080);
        check_eq("r033a_sel", 32'(SEL), 32'h7);

        // same drop but the other requester is disabled
        do_reset();
        cycle("r033b", 1'b0, 16'h0008, 16'hFFFF, 1'b0);
        cycle("r033b", 1'b0, 16'h0080, 16'hFF7F, 1'b0);
        check_eq("r033b_gnt", 32'(GNT), 32'h0);
        check_eq("r033b_busy", 32'(BUSY), 32'h0);
        check_eq("r033b_sel", 32'(SEL), 32'h3);

        // reset during a grant
        do_reset();
        cycle("r034", 1'b0, 16'h0200, 16'hFFFF, 1'b0);
        check_eq("r034_sel9", 32'(SEL), 32'h9);
        cycle("r034", 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        check_eq("r034_rst_gnt", 32'(GNT), 32'h0);
        check_eq("r034_rst_sel", 32'(SEL), 32'h0);
        check_eq("r034_rst_busy", 32'(BUSY), 32'h0);
        cycle("r034", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        check_eq("r034_first", 32'(GNT), 32'h0001);

        // random traffic
        do_reset();
        track_starve = 1'b1;
        rreq = 16'($urandom);
        for (int n = 0; n < 10000; n++) begin
            r    = $urandom & $urandom & $urandom;
            rreq = rreq ^ r[15:0];
            r    = $urandom & $urandom & $urandom & $urandom;
            ren  = ~r[15:0];
            cycle("rand", ($urandom_range(0, 499) == 0), rreq, ren, ($urandom_range(0, 3) == 0));
        end
        check_eq("starve_bound", 32'(max_wait <= 16 * HOLD), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
